// File: rtl/mo_line_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ==== mo_line_feeder : motion-object pixel serialiser, line-buffer address and buffer-select generator ====
// ==== Revision 1.0 ====
module mo_line_feeder #(
   parameter logic [2:0] TRANSP = 3'b111
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ce_pix,
   input  logic        hline,
   input  logic        obj_valid,
   output logic        obj_ready,
   input  logic [7:0]  obj_x,
   input  logic [23:0] obj_gfx,
   input  logic        obj_flip,
   input  logic        obj_prio,
   output logic [2:0]  ar,
   output logic        sr7,
   output logic        dip2,
   output logic [7:0]  addr1,
   output logic [7:0]  addr2,
   output logic        busy
);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_DRAW = 1'b1} state_t;

   state_t      r_state, w_state;
   logic [2:0]  r_pcnt, w_pcnt;
   logic [23:0] r_gfx, w_gfx;
   logic        r_flip, w_flip;
   logic        r_prio, w_prio;
   logic [7:0]  r_x, w_x;
   logic [7:0]  r_wr_addr, w_wr_addr;
   logic [2:0]  r_ar, w_ar;
   logic        r_sr7, w_sr7;
   logic        r_dip2, w_dip2;
   logic [7:0]  r_dcnt, w_dcnt;
   logic        r_pix_on, w_pix_on;

   logic [2:0]  w_idx;
   logic [4:0]  w_sh;
   logic [2:0]  w_pix;
   logic        w_accept;

   assign obj_ready = (r_state == S_IDLE) || (r_pcnt == 3'd7);
   assign w_accept  = obj_valid && obj_ready && !hline;

   assign w_idx = r_flip ? (3'd7 - r_pcnt) : r_pcnt;
   assign w_sh  = {1'b0, w_idx, 1'b0} + {2'b00, w_idx};
   assign w_pix = r_gfx[5'd21 - w_sh +: 3];

   // The write address is loaded from the latched start position when pixel 0
   // is emitted, so the previous row's last pixel keeps its own address.
   always_comb begin
      w_state   = r_state;
      w_pcnt    = r_pcnt;
      w_gfx     = r_gfx;
      w_flip    = r_flip;
      w_prio    = r_prio;
      w_x       = r_x;
      w_wr_addr = r_wr_addr;
      w_ar      = r_ar;
      w_sr7     = r_sr7;
      w_dip2    = r_dip2;
      w_dcnt    = r_dcnt + 8'd1;
      w_pix_on  = r_pix_on;
      if (hline) begin
         w_state  = S_IDLE;
         w_ar     = TRANSP;
         w_sr7    = 1'b0;
         w_pix_on = 1'b0;
         w_dip2   = ~r_dip2;
         w_dcnt   = 8'd0;
      end else begin
         case (r_state)
            S_DRAW: begin
               w_ar      = w_pix;
               w_sr7     = r_prio;
               w_pix_on  = 1'b1;
               w_wr_addr = (r_pcnt == 3'd0) ? r_x : r_wr_addr + 8'd1;
               w_pcnt    = r_pcnt + 3'd1;
               if (r_pcnt == 3'd7) w_state = S_IDLE;
            end
            default: begin
               w_ar     = TRANSP;
               w_sr7    = 1'b0;
               w_pix_on = 1'b0;
            end
         endcase
         if (w_accept) begin
            w_gfx   = obj_gfx;
            w_flip  = obj_flip;
            w_prio  = obj_prio;
            w_x     = obj_x;
            w_pcnt  = 3'd0;
            w_state = S_DRAW;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_pcnt    <= 3'd0;
         r_gfx     <= 24'd0;
         r_flip    <= 1'b0;
         r_prio    <= 1'b0;
         r_x       <= 8'd0;
         r_wr_addr <= 8'd0;
         r_ar      <= TRANSP;
         r_sr7     <= 1'b0;
         r_dip2    <= 1'b0;
         r_dcnt    <= 8'd0;
         r_pix_on  <= 1'b0;
      end else if (ce_pix) begin
         r_state   <= w_state;
         r_pcnt    <= w_pcnt;
         r_gfx     <= w_gfx;
         r_flip    <= w_flip;
         r_prio    <= w_prio;
         r_x       <= w_x;
         r_wr_addr <= w_wr_addr;
         r_ar      <= w_ar;
         r_sr7     <= w_sr7;
         r_dip2    <= w_dip2;
         r_dcnt    <= w_dcnt;
         r_pix_on  <= w_pix_on;
      end
   end

   // busy also covers the final pixel period, while the last code is still on ar.
   assign busy  = (r_state == S_DRAW) || r_pix_on;
   assign ar    = r_ar;
   assign sr7   = r_sr7;
   assign dip2  = r_dip2;
   assign addr1 = r_dip2 ? r_dcnt : r_wr_addr;
   assign addr2 = r_dip2 ? r_wr_addr : r_dcnt;

endmodule
`default_nettype wire

// File: tb/tb_mo_line_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ==== tb_mo_line_feeder : bench for mo_line_feeder against a pixel-queue model ====
// ==== Revision 1.0 ====
module tb_mo_line_feeder;

   logic        clk = 1'b0;
   logic        reset_n, ce_pix, hline, obj_valid, obj_flip, obj_prio;
   logic        obj_ready, sr7, dip2, busy;
   logic [7:0]  obj_x, addr1, addr2;
   logic [23:0] obj_gfx;
   logic [2:0]  ar;

   always #5 clk = ~clk;

   mo_line_feeder #(.TRANSP(3'b111)) dut (
      .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .hline(hline),
      .obj_valid(obj_valid), .obj_ready(obj_ready), .obj_x(obj_x),
      .obj_gfx(obj_gfx), .obj_flip(obj_flip), .obj_prio(obj_prio),
      .ar(ar), .sr7(sr7), .dip2(dip2), .addr1(addr1), .addr2(addr2), .busy(busy)
   );

   // Model: pending pixels of accepted rows, one popped per pixel tick.
   typedef struct {logic [2:0] code; logic [7:0] addr; logic prio;} pix_t;
   pix_t        q[$];
   logic [2:0]  m_ar;
   logic        m_sr7, m_on, m_dip2;
   logic [7:0]  m_wr, m_dcnt;
   int          n_acc = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ar = 3'd7; m_sr7 = 1'b0; m_on = 1'b0; m_dip2 = 1'b0;
      m_wr = 8'd0; m_dcnt = 8'd0;
   endtask

   function automatic logic [2:0] pix_of(input logic [23:0] g, input int j);
      return 3'((g >> (21 - 3 * j)) & 24'h7);
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".ar"},    {5'd0, ar},        {5'd0, m_ar});
      check({tag, ".sr7"},   {7'd0, sr7},       {7'd0, m_sr7});
      check({tag, ".dip2"},  {7'd0, dip2},      {7'd0, m_dip2});
      check({tag, ".addr1"}, addr1,             m_dip2 ? m_dcnt : m_wr);
      check({tag, ".addr2"}, addr2,             m_dip2 ? m_wr : m_dcnt);
      check({tag, ".busy"},  {7'd0, busy},      {7'd0, (q.size() != 0) || m_on});
      check({tag, ".ready"}, {7'd0, obj_ready}, {7'd0, q.size() <= 1});
   endtask

   task automatic tick(input logic ce, input logic hl, input string tag);
      logic rdy;
      pix_t e;
      @(negedge clk);
      ce_pix = ce;
      hline  = hl;
      @(posedge clk);
      if (ce) begin
         rdy = (q.size() <= 1);
         if (hl) begin
            q.delete();
            m_ar = 3'd7; m_sr7 = 1'b0; m_on = 1'b0;
            m_dip2 = ~m_dip2; m_dcnt = 8'd0;
         end else begin
            if (q.size() > 0) begin
               e = q.pop_front();
               m_ar = e.code; m_sr7 = e.prio; m_wr = e.addr; m_on = 1'b1;
            end else begin
               m_ar = 3'd7; m_sr7 = 1'b0; m_on = 1'b0;
            end
            m_dcnt = m_dcnt + 8'd1;
            if (obj_valid && rdy) begin
               n_acc++;
               for (int k = 0; k < 8; k++)
                  q.push_back('{pix_of(obj_gfx, obj_flip ? 7 - k : k), obj_x + 8'(k), obj_prio});
            end
         end
      end
      #1 check_all(tag);
   endtask

   task automatic set_desc(input logic v, input logic [7:0] x, input logic [23:0] g,
                           input logic f, input logic p);
      obj_valid = v; obj_x = x; obj_gfx = g; obj_flip = f; obj_prio = p;
   endtask

   initial begin
      int base;
      reset_n = 1'b0; ce_pix = 1'b0; hline = 1'b0;
      set_desc(1'b0, 8'h00, 24'h0, 1'b0, 1'b0);
      model_reset();
      #12;
      check_all("reset");
      check("reset.ar_const", {5'd0, ar}, 8'd7);
      check("reset.addr1_const", addr1, 8'd0);
      @(negedge clk) reset_n = 1'b1;

      tick(1'b1, 1'b0, "idle");
      tick(1'b1, 1'b1, "hline0");
      check("hline0.dip2_const", {7'd0, dip2}, 8'd1);
      check("hline0.addr1_zero", addr1, 8'd0);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, "count");

      // Plain row, then flipped row wrapping past address 255.
      set_desc(1'b1, 8'h40, 24'h053977, 1'b0, 1'b1);
      tick(1'b1, 1'b0, "row_acc");
      obj_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, "row");
      check("row.end_busy", {7'd0, busy}, 8'd0);
      set_desc(1'b1, 8'hFC, 24'h053977, 1'b1, 1'b0);
      tick(1'b1, 1'b0, "flip_acc");
      obj_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, "flip_freeze");
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, "flip");

      // Back-to-back rows: valid stays high until the second row is taken.
      base = n_acc;
      set_desc(1'b1, 8'h10, 24'h053977, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         if (n_acc == base + 1) set_desc(1'b1, 8'h80, 24'hFAC688, 1'b0, 1'b0);
         if (n_acc >= base + 2) obj_valid = 1'b0;
         tick(1'b1, 1'b0, "b2b");
      end

      // Abort at the 4th pixel.
      set_desc(1'b1, 8'h20, 24'h053977, 1'b0, 1'b1);
      tick(1'b1, 1'b0, "abort_acc");
      obj_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, "abort_pre");
      obj_valid = 1'b1;
      tick(1'b1, 1'b1, "abort");
      check("abort.busy_const", {7'd0, busy}, 8'd0);
      check("abort.ar_const", {5'd0, ar}, 8'd7);
      obj_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, "abort_post");

      // Asynchronous reset mid-row.
      set_desc(1'b1, 8'h55, 24'h053977, 1'b1, 1'b1);
      tick(1'b1, 1'b0, "rst_acc");
      obj_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, "rst_pre");
      @(negedge clk);
      ce_pix = 1'b0;
      #2 reset_n = 1'b0;
      model_reset();
      #1 check_all("rst_mid");
      check("rst_mid.busy_const", {7'd0, busy}, 8'd0);
      @(negedge clk) reset_n = 1'b1;
      set_desc(1'b1, 8'h33, 24'h053977, 1'b0, 1'b1);
      tick(1'b1, 1'b0, "rst_post_acc");
      obj_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, "rst_post");

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         set_desc($urandom_range(0, 9) < 7, 8'($urandom), 24'($urandom),
                  1'($urandom), 1'($urandom));
         tick($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
